seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

Display-side monitor that recovers hex digits from the multiplexed, active-low seven-segment bus driven by the CPU's display path. It samples segment and digit-strobe lines, requires each pattern to be stable before accepting it, reverse-maps it to a nibble, and assembles a full multi-digit frame. The frame is presented on a valid/ready output so the display path can be checked end-to-end in system test harnesses and on the board.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required to accept a digit (2..255)

Ports:
- clock  input  1  system clock; all logic on rising edge
- n_reset  input  1  synchronous, active-low reset
- seg  input  7  segment lines, active-low; seg[0]=a … seg[6]=g
- anode  input  DIGITS  digit strobes, active-low; anode[i]=0 selects digit i
- value  output  4*DIGITS  captured frame; digit i in value[4i+3:4i]
- blank  output  DIGITS  digit i showed all-segments-off (nibble reads 0)
- error  output  1  at least one digit in the frame had an unmapped pattern
- value_valid  output  1  frame available
- value_ready  input  1  consumer accepts frame
- overrun  output  1  one-cycle pulse: completed frame dropped

## Operation
- Sample register holds the previous cycle's {seg, anode}. Reset value is all-ones.
- Strobe is legal only when exactly one anode bit is 0. Illegal strobe (none or several low) clears the stability counter; nothing is captured.
- Stability counter:
  - increments while the sample equals the previous sample and the strobe is legal; saturates at STABLE_CYCLES;
  - resets to 1 on any change (0 if the strobe is illegal).
- Capture fires once per dwell, on the cycle the counter reaches STABLE_CYCLES. It writes the decoded nibble plus blank/err bits into digit slot i and sets captured[i].
- A re-capture of a digit already captured this frame overwrites that slot.
- Decode table (seg[6:0] to nibble):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=B
  - 1000110=C, 0100001=D, 0000110=E, 0001110=F
  - 1111111 gives nibble 0 with the slot's blank bit set.
  - Any other pattern gives nibble 0 with the slot's err bit set.
- Frame complete: captured is all-ones, either registered or becoming so this cycle.
  - If the output is empty, or value_valid && value_ready this cycle: load value, blank, and error (OR of slot err bits); set value_valid.
  - Otherwise: drop the frame and pulse overrun.
  - In both cases captured clears, and the slots become ready for the next frame.
- Output handshake:
  - value, blank, and error are held stable while value_valid is 1 and value_ready is 0.
  - value_valid clears on value_ready unless a new frame loads in the same cycle; in that case it stays 1 with the new data.
- Reset, including mid-frame or with a frame pending: all outputs 0, captured 0, counter 0, slots 0, sample register all-ones.

## Timing
- Capture latency: the digit pattern must first appear on cycle t0 and remain through t0+STABLE_CYCLES-1. Capture registers on that last edge.
- The frame-complete capture on cycle t loads the outputs at the same edge: value_valid is 1 from cycle t+1.
- overrun is high for exactly the cycle after the dropping edge.
- value_ready is ignored while value_valid is 0.
- Dwells shorter than STABLE_CYCLES are ignored entirely; this is the ghosting/transition filter.
- Simultaneous consume and frame-complete: new frame loads, no overrun, no bubble.

## Test plan
- Settle test, STABLE_CYCLES=4, DIGITS=4, value_ready=1: scan digits 0..3 with patterns 1/2/3/4, 6 cycles each. Required: value=16'h4321, blank=0, error=0, value_valid for 1 cycle after the last capture.
- Glitch filter: digit 1 shows 0000010 for 3 cycles, then 0000011 for 6 cycles. Required: slot 1 = B; the 6 is never captured.
- Blank and illegal patterns: digit 0 = 1111111, digit 2 = 0101010. Required: blank=4'b0001, error=1, nibbles 0 in both slots.
- Backpressure: value_ready=0, complete two frames. Required: first frame held unchanged; overrun pulses once at second completion. Then raise value_ready: value_valid drops next cycle.
- Illegal strobe: anode=4'b0011 for 10 cycles, then anode=4'b1111 for 10 cycles. Required: no capture, value_valid stays 0.
- Reset mid-frame: after 2 of 4 digits captured, pull n_reset low for 1 cycle, then send a full frame. Required: only the post-reset digits appear in value, and all outputs are 0 during reset.

Source files
------------

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//
// Monitors a multiplexed, active-low seven-segment bus and recovers the hex
// digits it shows. A {seg, anode} pattern must hold for STABLE_CYCLES
// consecutive samples with exactly one strobe low before it is decoded into
// that digit's slot. When every digit has been captured, the frame is offered
// on a valid/ready output. If the previous frame has not been consumed, the new
// frame is dropped and overrun pulses.
//
// Ports:
//   clock        system clock, rising edge
//   n_reset      synchronous active-low reset
//   seg[6:0]     segment lines a..g, active-low
//   anode        digit strobes, active-low, one-hot-low when legal
//   value        captured frame, digit i in value[4i+3:4i]
//   blank        per-digit "all segments off" flag
//   error        some digit of the frame showed an unmapped pattern
//   value_valid  frame available
//   value_ready  consumer accepts frame
//   overrun      one-cycle pulse when a completed frame is dropped

module seven_seg_capture #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  n_reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     anode,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank,
    output logic                  error,
    output logic                  value_valid,
    input  logic                  value_ready,
    output logic                  overrun
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    // Decoded pattern: {err, blank, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        unique case (s)
            7'b1000000: r = 6'h00;
            7'b1111001: r = 6'h01;
            7'b0100100: r = 6'h02;
            7'b0110000: r = 6'h03;
            7'b0011001: r = 6'h04;
            7'b0010010: r = 6'h05;
            7'b0000010: r = 6'h06;
            7'b1111000: r = 6'h07;
            7'b0000000: r = 6'h08;
            7'b0010000: r = 6'h09;
            7'b0001000: r = 6'h0a;
            7'b0000011: r = 6'h0b;
            7'b1000110: r = 6'h0c;
            7'b0100001: r = 6'h0d;
            7'b0000110: r = 6'h0e;
            7'b0001110: r = 6'h0f;
            7'b1111111: r = 6'b01_0000;
            default:    r = 6'b10_0000;
        endcase
        return r;
    endfunction

    logic [6+DIGITS:0]   samp_q;
    logic [6+DIGITS:0]   cur;
    logic [DIGITS-1:0]   sel;
    logic                legal;
    logic [7:0]          cnt_q, cnt_d;
    logic                capture;
    logic [5:0]          dec;

    logic [4*DIGITS-1:0] nib_q, nib_d;
    logic [DIGITS-1:0]   blk_q, blk_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic [DIGITS-1:0]   captured_q, captured_d;
    logic                complete;
    logic                load;

    assign cur   = {seg, anode};
    assign sel   = ~anode;
    // Exactly one strobe low: non-zero and a power of two.
    assign legal = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
    assign dec   = decode(seg);

    always_comb begin
        cnt_d = cnt_q;
        if (!legal) begin
            cnt_d = 8'd0;
        end else if (cur == samp_q) begin
            if (cnt_q != STABLE) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = 8'd1;
        end
    end

    // Fires only on the cycle the counter arrives at STABLE, once per dwell.
    assign capture = legal && (cnt_d == STABLE) && (cnt_q != STABLE);

    always_comb begin
        nib_d      = nib_q;
        blk_d      = blk_q;
        err_d      = err_q;
        captured_d = captured_q;
        if (capture) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (sel[i]) begin
                    nib_d[4*i +: 4] = dec[3:0];
                    blk_d[i]        = dec[4];
                    err_d[i]        = dec[5];
                    captured_d[i]   = 1'b1;
                end
            end
        end
    end

    assign complete = &captured_d;
    assign load     = complete && (!value_valid || value_ready);

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            samp_q      <= '1;
            cnt_q       <= 8'd0;
            nib_q       <= '0;
            blk_q       <= '0;
            err_q       <= '0;
            captured_q  <= '0;
            value       <= '0;
            blank       <= '0;
            error       <= 1'b0;
            value_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            samp_q     <= cur;
            cnt_q      <= cnt_d;
            nib_q      <= nib_d;
            blk_q      <= blk_d;
            err_q      <= err_d;
            captured_q <= complete ? '0 : captured_d;
            overrun    <= complete && !load;
            if (load) begin
                value       <= nib_d;
                blank       <= blk_d;
                error       <= |err_d;
                value_valid <= 1'b1;
            end else if (value_ready) begin
                value_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
module tb_seven_seg_capture;

    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000, PA = 7'b0001000, PB = 7'b0000011;
    localparam logic [6:0] PC = 7'b1000110, PF = 7'b0001110;
    localparam logic [6:0] PBLANK = 7'b1111111, PBAD = 7'b0101010;

    logic        clock = 1'b0;
    logic        n_reset = 1'b0;
    logic [6:0]  seg = 7'h7f;
    logic [3:0]  anode = 4'hf;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        error;
    logic        value_valid;
    logic        value_ready = 1'b0;
    logic        overrun;

    int pass_cnt = 0;
    int total    = 0;

    // Observations gathered one cycle at a time.
    int          vcount;
    int          ocount;
    logic [15:0] last_val;
    logic [3:0]  last_blank;
    logic        last_err;

    seven_seg_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .seg         (seg),
        .anode       (anode),
        .value       (value),
        .blank       (blank),
        .error       (error),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    task automatic clear_mon();
        vcount = 0;
        ocount = 0;
        last_val = 16'h0;
        last_blank = 4'h0;
        last_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (value_valid) begin
            vcount++;
            last_val = value;
            last_blank = blank;
            last_err = error;
        end
        if (overrun) ocount++;
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        logic [3:0] one;
        one = 4'b0001;
        anode = ~(one << d);
        seg = s;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        anode = 4'hf;
        seg = 7'h7f;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) tick();
        total++; if (value !== 16'h0) $display("FAIL reset_value got %h want 0000", value); else pass_cnt++;
        total++; if (blank !== 4'h0) $display("FAIL reset_blank got %b want 0000", blank); else pass_cnt++;
        total++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else pass_cnt++;
        total++; if (value_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", value_valid); else pass_cnt++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else pass_cnt++;
        n_reset = 1'b1;
        idle(2);
    endtask

    task automatic test_settle();
        value_ready = 1'b1;
        clear_mon();
        show(0, P1, 6); show(1, P2, 6); show(2, P3, 6); show(3, P4, 6);
        idle(2);
        total++; if (vcount !== 1) $display("FAIL settle_valid_cycles got %0d want 1", vcount); else pass_cnt++;
        total++; if (last_val !== 16'h4321) $display("FAIL settle_value got %h want 4321", last_val); else pass_cnt++;
        total++; if (last_blank !== 4'h0) $display("FAIL settle_blank got %b want 0000", last_blank); else pass_cnt++;
        total++; if (last_err !== 1'b0) $display("FAIL settle_error got %b want 0", last_err); else pass_cnt++;
        total++; if (value_valid !== 1'b0) $display("FAIL settle_valid_after got %b want 0", value_valid); else pass_cnt++;
        total++; if (ocount !== 0) $display("FAIL settle_overrun got %0d want 0", ocount); else pass_cnt++;
    endtask

    task automatic test_glitch();
        value_ready = 1'b1;
        clear_mon();
        show(0, P0, 6); show(2, P5, 6); show(3, P7, 6);
        show(1, P6, 3);  // too short: must not complete the frame
        show(1, PB, 6);
        idle(2);
        total++; if (vcount !== 1) $display("FAIL glitch_valid_cycles got %0d want 1", vcount); else pass_cnt++;
        total++; if (last_val !== 16'h75b0) $display("FAIL glitch_value got %h want 75b0", last_val); else pass_cnt++;
        total++; if (last_err !== 1'b0) $display("FAIL glitch_error got %b want 0", last_err); else pass_cnt++;
    endtask

    task automatic test_blank_illegal();
        value_ready = 1'b1;
        clear_mon();
        show(0, PBLANK, 6); show(1, P9, 6); show(2, PBAD, 6); show(3, PF, 6);
        idle(2);
        total++; if (vcount !== 1) $display("FAIL blank_valid_cycles got %0d want 1", vcount); else pass_cnt++;
        total++; if (last_val !== 16'hf090) $display("FAIL blank_value got %h want f090", last_val); else pass_cnt++;
        total++; if (last_blank !== 4'b0001) $display("FAIL blank_bits got %b want 0001", last_blank); else pass_cnt++;
        total++; if (last_err !== 1'b1) $display("FAIL blank_error got %b want 1", last_err); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        value_ready = 1'b0;
        clear_mon();
        show(0, P1, 6); show(1, P2, 6); show(2, P3, 6); show(3, P4, 6);
        total++; if (value_valid !== 1'b1) $display("FAIL bp_first_valid got %b want 1", value_valid); else pass_cnt++;
        total++; if (value !== 16'h4321) $display("FAIL bp_first_value got %h want 4321", value); else pass_cnt++;
        show(0, P8, 6); show(1, P9, 6); show(2, PA, 6); show(3, PC, 6);
        idle(1);
        total++; if (ocount !== 1) $display("FAIL bp_overrun_cycles got %0d want 1", ocount); else pass_cnt++;
        total++; if (value !== 16'h4321) $display("FAIL bp_held_value got %h want 4321", value); else pass_cnt++;
        total++; if (value_valid !== 1'b1) $display("FAIL bp_held_valid got %b want 1", value_valid); else pass_cnt++;
        value_ready = 1'b1;
        tick();
        total++; if (value_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", value_valid); else pass_cnt++;
    endtask

    task automatic test_illegal_strobe();
        value_ready = 1'b1;
        clear_mon();
        anode = 4'b0011; seg = P1;
        repeat (10) tick();
        anode = 4'b1111;
        repeat (10) tick();
        total++; if (vcount !== 0) $display("FAIL illegal_valid_cycles got %0d want 0", vcount); else pass_cnt++;
        // If digits 2/3 had been captured, these two would complete a frame.
        show(0, P5, 6); show(1, P6, 6);
        idle(2);
        total++; if (vcount !== 0) $display("FAIL illegal_no_capture got %0d want 0", vcount); else pass_cnt++;
        total++; if (ocount !== 0) $display("FAIL illegal_overrun got %0d want 0", ocount); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        // Slots 0 and 1 already hold 5 and 6 from the previous scenario.
        value_ready = 1'b1;
        anode = 4'hf; seg = 7'h7f;
        n_reset = 1'b0;
        tick();
        total++; if (value !== 16'h0) $display("FAIL midrst_value got %h want 0000", value); else pass_cnt++;
        total++; if (blank !== 4'h0) $display("FAIL midrst_blank got %b want 0000", blank); else pass_cnt++;
        total++; if (error !== 1'b0) $display("FAIL midrst_error got %b want 0", error); else pass_cnt++;
        total++; if (value_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", value_valid); else pass_cnt++;
        total++; if (overrun !== 1'b0) $display("FAIL midrst_overrun got %b want 0", overrun); else pass_cnt++;
        n_reset = 1'b1;
        clear_mon();
        show(2, PB, 6);
        total++; if (vcount !== 0) $display("FAIL midrst_early_frame got %0d want 0", vcount); else pass_cnt++;
        show(3, PC, 6); show(0, P9, 6); show(1, PA, 6);
        idle(2);
        total++; if (vcount !== 1) $display("FAIL midrst_valid_cycles got %0d want 1", vcount); else pass_cnt++;
        total++; if (last_val !== 16'hcba9) $display("FAIL midrst_value_after got %h want cba9", last_val); else pass_cnt++;
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_settle();
        test_glitch();
        test_blank_illegal();
        test_backpressure();
        test_illegal_strobe();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
